// File: rtl/cmp_stream_tracker_pkg.sv
// Shared state encoding and default widths for the frame max/min tracker.
package cmp_stream_tracker_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/cmp_stream_tracker_mag_cmp.sv
// Unsigned WIDTH-bit magnitude comparator: exactly one of agb/alb/aeqb is high.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             agb,
  output logic             alb,
  output logic             aeqb
);
  assign agb  = (a > b);
  assign alb  = (a < b);
  assign aeqb = (a == b);
endmodule

// File: rtl/cmp_stream_tracker.sv
// Accepts a framed sample stream and reports per-frame max/min, their first
// indices and the saturating sample count, held until the consumer takes it.
module cmp_stream_tracker
  import cmp_stream_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] min_idx,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             cnt_ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   accept;
  logic   gt_max, lt_max, eq_max;
  logic   gt_min, lt_min, eq_min;
  logic   upd_max, upd_min;

  // Handshake flags depend only on the registered state.
  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a    (in_data),
    .b    (max_val),
    .agb  (gt_max),
    .alb  (lt_max),
    .aeqb (eq_max)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a    (in_data),
    .b    (min_val),
    .agb  (gt_min),
    .alb  (lt_min),
    .aeqb (eq_min)
  );

  // Equal samples never replace the stored extreme, so the first occurrence wins.
  assign upd_max = gt_max && !eq_max && !lt_max;
  assign upd_min = lt_min && !eq_min && !gt_min;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? HOLD : ACC;
      ACC:     if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_val    <= '0;
      min_val    <= '0;
      max_idx    <= '0;
      min_idx    <= '0;
      sample_cnt <= '0;
      cnt_ovf    <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        max_val    <= in_data;
        min_val    <= in_data;
        max_idx    <= '0;
        min_idx    <= '0;
        sample_cnt <= CNT_W'(1);
        cnt_ovf    <= 1'b0;
      end else begin
        // sample_cnt is the 0-based index of this beat, saturated.
        if (upd_max) begin
          max_val <= in_data;
          max_idx <= sample_cnt;
        end
        if (upd_min) begin
          min_val <= in_data;
          min_idx <= sample_cnt;
        end
        if (sample_cnt == CNT_MAX) cnt_ovf <= 1'b1;
        else                       sample_cnt <= sample_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Checks a default-width tracker and a 3-bit-counter tracker driven by the same stream.
module tb_cmp_stream_tracker;
  logic       clk, rst;
  logic       in_valid, in_last, out_ready;
  logic [3:0] in_data;

  logic       in_ready_a, out_valid_a, cnt_ovf_a;
  logic [3:0] max_val_a, min_val_a;
  logic [7:0] max_idx_a, min_idx_a, sample_cnt_a;

  logic       in_ready_s, out_valid_s, cnt_ovf_s;
  logic [3:0] max_val_s, min_val_s;
  logic [2:0] max_idx_s, min_idx_s, sample_cnt_s;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] mx, mn;
    int         mxi, mni, cnt;
    int         ovf;
  } res_t;

  typedef struct {
    int          n;
    logic [31:0] d;    // sample i in nibble i
    int          gap;
    int          hold;
    res_t        e;
  } vec_t;

  cmp_stream_tracker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
    .out_ready(out_ready), .max_val(max_val_a), .min_val(min_val_a),
    .max_idx(max_idx_a), .min_idx(min_idx_a), .sample_cnt(sample_cnt_a),
    .cnt_ovf(cnt_ovf_a)
  );

  cmp_stream_tracker #(.WIDTH(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_s),
    .out_ready(out_ready), .max_val(max_val_s), .min_val(min_val_s),
    .max_idx(max_idx_s), .min_idx(min_idx_s), .sample_cnt(sample_cnt_s),
    .cnt_ovf(cnt_ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_hs(input string tag, input int rdy, input int vld);
    chk({tag, ".a.in_ready"}, int'(in_ready_a), rdy);
    chk({tag, ".a.out_valid"}, int'(out_valid_a), vld);
    chk({tag, ".s.in_ready"}, int'(in_ready_s), rdy);
    chk({tag, ".s.out_valid"}, int'(out_valid_s), vld);
  endtask

  task automatic chk_res(input string tag, input res_t ea, input res_t es);
    chk({tag, ".a.max"}, int'(max_val_a), int'(ea.mx));
    chk({tag, ".a.min"}, int'(min_val_a), int'(ea.mn));
    chk({tag, ".a.max_idx"}, int'(max_idx_a), ea.mxi);
    chk({tag, ".a.min_idx"}, int'(min_idx_a), ea.mni);
    chk({tag, ".a.cnt"}, int'(sample_cnt_a), ea.cnt);
    chk({tag, ".a.ovf"}, int'(cnt_ovf_a), ea.ovf);
    chk({tag, ".s.max"}, int'(max_val_s), int'(es.mx));
    chk({tag, ".s.min"}, int'(min_val_s), int'(es.mn));
    chk({tag, ".s.max_idx"}, int'(max_idx_s), es.mxi);
    chk({tag, ".s.min_idx"}, int'(min_idx_s), es.mni);
    chk({tag, ".s.cnt"}, int'(sample_cnt_s), es.cnt);
    chk({tag, ".s.ovf"}, int'(cnt_ovf_s), es.ovf);
  endtask

  // Reference: extremes over the whole frame, first occurrence kept,
  // indices and count clipped to the counter range.
  function automatic res_t model(input logic [3:0] q[$], input int cw);
    res_t r;
    int cap = (1 << cw) - 1;
    r.mx = q[0]; r.mn = q[0]; r.mxi = 0; r.mni = 0;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] > r.mx) begin r.mx = q[i]; r.mxi = (i < cap) ? i : cap; end
      if (q[i] < r.mn) begin r.mn = q[i]; r.mni = (i < cap) ? i : cap; end
    end
    r.cnt = (q.size() < cap) ? q.size() : cap;
    r.ovf = (q.size() > cap) ? 1 : 0;
    return r;
  endfunction

  task automatic send_beat(input logic [3:0] v, input logic l, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = v;
    in_last  = l;
    while (!in_ready_a && t < 50) begin step(); t++; end
    if (t >= 50) begin
      errors++; checks++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int t = 0;
    while (!out_valid_a && t < 100) begin step(); t++; end
    checks++;
    if (t >= 100) begin
      errors++;
      $display("FAIL %s.out_valid_timeout: got 0 expected 1", tag);
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_hs({tag, ".idle"}, 1, 0);
  endtask

  vec_t vt[4];

  initial begin
    logic [3:0] q[$];
    res_t ea, es;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    ea = '{mx: 4'd0, mn: 4'd0, mxi: 0, mni: 0, cnt: 0, ovf: 0};
    chk_hs("reset", 1, 0);
    chk_res("reset", ea, ea);
    #10 rst = 1'b0;
    step();

    vt[0] = '{n: 5, d: 32'h0001_9193, gap: 0, hold: 0,
              e: '{mx: 4'd9, mn: 4'd1, mxi: 1, mni: 2, cnt: 5, ovf: 0}};
    vt[1] = '{n: 1, d: 32'h0000_000A, gap: 0, hold: 5,
              e: '{mx: 4'd10, mn: 4'd10, mxi: 0, mni: 0, cnt: 1, ovf: 0}};
    vt[2] = '{n: 4, d: 32'h0000_00FF, gap: 2, hold: 0,
              e: '{mx: 4'd15, mn: 4'd0, mxi: 0, mni: 2, cnt: 4, ovf: 0}};
    vt[3] = '{n: 6, d: 32'h0072_7255, gap: 1, hold: 2,
              e: '{mx: 4'd7, mn: 4'd2, mxi: 3, mni: 2, cnt: 6, ovf: 0}};

    for (int k = 0; k < 4; k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      for (int i = 0; i < vt[k].n; i++)
        send_beat(vt[k].d[i*4 +: 4], (i == vt[k].n - 1), vt[k].gap);
      chk_hs({tag, ".hold"}, 0, 1);
      chk_res(tag, vt[k].e, vt[k].e);
      for (int h = 0; h < vt[k].hold; h++) begin
        step();
        chk_hs({tag, ".stall"}, 0, 1);
        chk({tag, ".stall.max"}, int'(max_val_a), int'(vt[k].e.mx));
        chk({tag, ".stall.min_idx"}, int'(min_idx_a), vt[k].e.mni);
      end
      release_result(tag);
    end

    // Counter saturation: 10 beats 0..9.
    for (int i = 0; i < 10; i++) send_beat(4'(i), (i == 9), 0);
    ea = '{mx: 4'd9, mn: 4'd0, mxi: 9, mni: 0, cnt: 10, ovf: 0};
    es = '{mx: 4'd9, mn: 4'd0, mxi: 7, mni: 0, cnt: 7, ovf: 1};
    chk_hs("sat.hold", 0, 1);
    chk_res("sat", ea, es);
    release_result("sat");

    // Asynchronous reset in the middle of a frame.
    send_beat(4'd4, 1'b0, 0);
    send_beat(4'd1, 1'b0, 0);
    send_beat(4'd6, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    ea = '{mx: 4'd0, mn: 4'd0, mxi: 0, mni: 0, cnt: 0, ovf: 0};
    chk_hs("midrst", 1, 0);
    chk_res("midrst", ea, ea);
    #3 rst = 1'b0;
    step();
    send_beat(4'd5, 1'b0, 0);
    send_beat(4'd2, 1'b1, 0);
    ea = '{mx: 4'd5, mn: 4'd2, mxi: 0, mni: 1, cnt: 2, ovf: 0};
    chk_res("after_rst", ea, ea);
    release_result("after_rst");

    // Back-to-back frames with out_ready held high.
    out_ready = 1'b1;
    send_beat(4'd7, 1'b0, 0);
    send_beat(4'd8, 1'b1, 0);
    chk_hs("b2b1.hold", 0, 1);
    ea = '{mx: 4'd8, mn: 4'd7, mxi: 1, mni: 0, cnt: 2, ovf: 0};
    chk_res("b2b1", ea, ea);
    send_beat(4'd2, 1'b1, 0);
    chk_hs("b2b2.hold", 0, 1);
    ea = '{mx: 4'd2, mn: 4'd2, mxi: 0, mni: 0, cnt: 1, ovf: 0};
    chk_res("b2b2", ea, ea);
    step();
    out_ready = 1'b0;
    chk_hs("b2b2.idle", 1, 0);

    // Random frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      int n, gap, hold;
      bit narrow;
      string tag;
      tag    = $sformatf("rnd%0d", f);
      n      = $urandom_range(1, 12);
      narrow = $urandom_range(0, 1);
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back(narrow ? 4'($urandom_range(0, 3)) : 4'($urandom));
      for (int i = 0; i < n; i++) begin
        gap = $urandom_range(0, 2);
        send_beat(q[i], (i == n - 1), gap);
      end
      wait_result(tag);
      ea = model(q, 8);
      es = model(q, 3);
      chk_res(tag, ea, es);
      hold = $urandom_range(0, 3);
      repeat (hold) step();
      chk({tag, ".held_cnt"}, int'(sample_cnt_a), ea.cnt);
      release_result(tag);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
